// File: rtl/instr_register_sched.sv
// Instruction register scheduler: clears the external register, then queues pushed instructions
// and prefetches the head into a registered output stage.
package instr_register_sched_pkg;
    typedef enum logic [3:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
    typedef logic signed [15:0] operand_t;
    typedef logic signed [31:0] result_t;
    typedef logic [4:0]         address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        result_t  rez_t;
    } instruction_t;
endpackage

module instr_register_sched
    import instr_register_sched_pkg::*;
#(
    parameter int unsigned AFULL_LEVEL = 28,
    parameter int unsigned DEPTH       = 2 ** $bits(address_t)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  opcode_t      in_opcode,
    input  operand_t     in_operand_a,
    input  operand_t     in_operand_b,
    input  logic         flush,
    output logic         load_en,
    output address_t     write_pointer,
    output opcode_t      opcode,
    output operand_t     operand_a,
    output operand_t     operand_b,
    output address_t     read_pointer,
    input  instruction_t instruction_word,
    output logic         out_valid,
    input  logic         out_ready,
    output instruction_t out_instruction,
    output logic [5:0]   count,
    output logic         empty,
    output logic         afull,
    output logic         busy
);

    typedef enum logic [1:0] {StClear, StRun, StFlush} state_e;

    state_e       state_q, state_d;
    address_t     clr_idx_q, clr_idx_d;
    address_t     head_q, head_d;
    address_t     tail_q, tail_d;
    logic [5:0]   count_q, count_d;
    logic         out_valid_q, out_valid_d;
    instruction_t out_instr_q, out_instr_d;

    logic push, prefetch, pop;

    always_comb begin
        state_d       = state_q;
        clr_idx_d     = clr_idx_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        out_valid_d   = out_valid_q;
        out_instr_d   = out_instr_q;
        in_ready      = 1'b0;
        load_en       = 1'b0;
        write_pointer = tail_q;
        opcode        = in_opcode;
        operand_a     = in_operand_a;
        operand_b     = in_operand_b;
        push          = 1'b0;
        prefetch      = 1'b0;
        pop           = 1'b0;

        unique case (state_q)
            StClear: begin
                load_en       = 1'b1;
                write_pointer = clr_idx_q;
                opcode        = ZERO;
                operand_a     = '0;
                operand_b     = '0;
                clr_idx_d     = clr_idx_q + 5'd1;
                if (clr_idx_q == address_t'(DEPTH - 1)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (flush) begin
                    // Discard everything; the pending push/pop on this edge is dropped.
                    state_d     = StFlush;
                    head_d      = '0;
                    tail_d      = '0;
                    count_d     = '0;
                    out_valid_d = 1'b0;
                    clr_idx_d   = '0;
                end else begin
                    in_ready = (count_q < 6'(DEPTH));
                    push     = in_valid && in_ready;
                    prefetch = (count_q != 6'd0) && (!out_valid_q || out_ready);
                    pop      = out_valid_q && out_ready;
                    load_en  = push;

                    if (push) begin
                        tail_d = tail_q + 5'd1;
                    end
                    // Head slot was written on an earlier edge, so the read data is settled.
                    if (prefetch) begin
                        out_instr_d = instruction_word;
                        head_d      = head_q + 5'd1;
                        out_valid_d = 1'b1;
                    end else if (pop) begin
                        out_valid_d = 1'b0;
                    end

                    if (push && !prefetch) begin
                        count_d = count_q + 6'd1;
                    end else if (prefetch && !push) begin
                        count_d = count_q - 6'd1;
                    end
                end
            end
            StFlush: begin
                state_d = StClear;
            end
            default: begin
                state_d = StClear;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StClear;
            clr_idx_q   <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
        end
    end

    assign read_pointer    = head_q;
    assign out_valid       = out_valid_q;
    assign out_instruction = out_instr_q;
    assign count           = count_q;
    assign empty           = (count_q == 6'd0) && !out_valid_q;
    assign afull           = (32'(count_q) >= AFULL_LEVEL);
    assign busy            = (state_q != StRun);

endmodule
